fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the CPU front end. Owns the fetch PC, drives a request/address-ok/data-ok instruction-memory handshake, and hands fetched words to the IF/ID stage. Sits between the instruction bus and the decode stage. Absorbs downstream stall, branch redirect and exception flush.

---
 rtl/fetch_ctrl_pkg.sv | 11 +
 rtl/fetch_ctrl_pc_next_sel.sv | 20 ++
 rtl/fetch_ctrl.sv | 93 +++++++++
 tb/tb_fetch_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, fetch FSM encodings and reset constants
package fetch_ctrl_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_REQ = 2'd1;
  localparam logic [1:0] FETCH_WAIT = 2'd2;
  localparam logic [1:0] FETCH_OUT = 2'd3;
  localparam logic [InstAddrBus-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic RST_ENABLE = 1'b0;
endpackage

// File: rtl/fetch_ctrl_pc_next_sel.sv
// pc_next_sel: next fetch PC, flush over branch over sequential, word aligned
module pc_next_sel
  import fetch_ctrl_pkg::*;
(
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] flush_pc,
  input  logic                   branch_flag,
  input  logic [InstAddrBus-1:0] branch_target,
  input  logic [InstAddrBus-1:0] pc,
  output logic                   redirect,
  output logic [InstAddrBus-1:0] nxt
);
  // redirect targets drop their low bits; the sequential path is already aligned
  always_comb begin
    redirect = flush | branch_flag;
    nxt = flush ? {flush_pc[InstAddrBus-1:2], 2'b00}
        : branch_flag ? {branch_target[InstAddrBus-1:2], 2'b00}
        : pc + 32'd4;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with one outstanding request
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] flush_pc,
  input  logic                   branch_flag,
  input  logic [InstAddrBus-1:0] branch_target,
  output logic                   inst_req,
  output logic [InstAddrBus-1:0] inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [InstBus-1:0]     inst_rdata,
  output logic [InstAddrBus-1:0] pc,
  output logic                   if_valid,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst
);
  logic [1:0] state;
  logic discard;
  logic redirect;
  logic [InstAddrBus-1:0] nxt;

  pc_next_sel u_sel (
    .flush(flush),
    .flush_pc(flush_pc),
    .branch_flag(branch_flag),
    .branch_target(branch_target),
    .pc(pc),
    .redirect(redirect),
    .nxt(nxt)
  );

  assign inst_req = state == FETCH_REQ;
  assign inst_addr = pc;

  // fetch FSM; discard marks an in-flight response made stale by a redirect
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= FETCH_IDLE;
      pc <= RESET_PC;
      discard <= 1'b0;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_inst <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          state <= FETCH_REQ;
          if (redirect) pc <= nxt;
        end
        FETCH_REQ: begin
          if (redirect) pc <= nxt;
          if (inst_addr_ok) begin
            state <= FETCH_WAIT;
            discard <= redirect;
          end
        end
        FETCH_WAIT: begin
          if (inst_data_ok) begin
            discard <= 1'b0;
            if (redirect) begin
              pc <= nxt;
              state <= FETCH_REQ;
            end else if (discard) begin
              state <= FETCH_REQ;
            end else begin
              if_pc <= pc;
              if_inst <= inst_rdata;
              if_valid <= 1'b1;
              state <= FETCH_OUT;
            end
          end else if (redirect) begin
            pc <= nxt;
            discard <= 1'b1;
          end
        end
        FETCH_OUT: begin
          if (redirect | ~stall) begin
            pc <= nxt;
            if_valid <= 1'b0;
            state <= FETCH_REQ;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, stall, flush, branch_flag;
  logic [31:0] flush_pc, branch_target;
  logic inst_req;
  logic [31:0] inst_addr;
  logic inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata, pc;
  logic if_valid;
  logic [31:0] if_pc, if_inst;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 0;
  int wcnt = 0;
  logic pend = 1'b0;
  logic saw_valid = 1'b0;
  logic [31:0] raddr = '0;
  int t0, t1;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .pc(pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h1111_1111 : a == 32'h4 ? 32'h2222_2222 : a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock; memory model accepts on req&addr_ok and answers lat cycles later
  task automatic tick;
    logic acc, dok;
    logic [31:0] a;
    acc = inst_req & inst_addr_ok;
    dok = inst_data_ok;
    a = inst_addr;
    @(posedge clk);
    #1;
    cyc++;
    saw_valid = saw_valid | if_valid;
    if (dok) begin
      pend = 1'b0;
      inst_data_ok = 1'b0;
    end
    if (acc) begin
      pend = 1'b1;
      wcnt = lat;
      raddr = a;
    end
    if (pend) begin
      if (wcnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata = mem(raddr);
      end else wcnt--;
    end
  endtask

  task automatic wait_req(input logic [31:0] exp, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!inst_req && n < 20);
    chk({tag, "_req"}, {31'd0, inst_req}, 32'd1);
    chk({tag, "_addr"}, inst_addr, exp);
  endtask

  task automatic wait_valid(input logic [31:0] epc, input logic [31:0] einst, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!if_valid && n < 20);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, epc);
    chk({tag, "_inst"}, if_inst, einst);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    flush_pc = '0; branch_target = '0;
    inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = '0;
    tick();
    tick();
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    rst = 1'b1;
    tick();
    chk("first_req", {31'd0, inst_req}, 32'd1);
    chk("first_addr", inst_addr, 32'h0);
    t0 = cyc;
    wait_valid(32'h0, 32'h1111_1111, "w0");
    wait_req(32'h4, "r4");
    t1 = cyc;
    chk("spacing", 32'(t1 - t0), 32'd3);
    wait_valid(32'h4, 32'h2222_2222, "w4");
    wait_req(32'h8, "r8");
    wait_valid(32'h8, mem(32'h8), "w8");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_if_pc", if_pc, 32'h8);
      chk("stall_if_inst", if_inst, mem(32'h8));
      chk("stall_noreq", {31'd0, inst_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_req", {31'd0, inst_req}, 32'd1);
    chk("unstall_addr", inst_addr, 32'hC);
    lat = 2;
    tick();
    branch_flag = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_flag = 1'b0;
    chk("br_wait_pc", pc, 32'h100);
    saw_valid = 1'b0;
    wait_req(32'h100, "br");
    chk("br_dropped", {31'd0, saw_valid}, 32'd0);
    lat = 0;
    wait_valid(32'h100, mem(32'h100), "w100");
    stall = 1'b1;
    flush = 1'b1; flush_pc = 32'h380;
    branch_flag = 1'b1; branch_target = 32'h200;
    tick();
    flush = 1'b0; branch_flag = 1'b0; stall = 1'b0;
    chk("fl_valid", {31'd0, if_valid}, 32'd0);
    chk("fl_req", {31'd0, inst_req}, 32'd1);
    chk("fl_addr", inst_addr, 32'h380);
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_flag = 1'b0;
    wait_req(32'hFFFF_FFFC, "rtop");
    wait_valid(32'hFFFF_FFFC, mem(32'hFFFF_FFFC), "wtop");
    wait_req(32'h0, "wrap");
    inst_addr_ok = 1'b0;
    branch_flag = 1'b1; branch_target = 32'h103;
    tick();
    branch_flag = 1'b0;
    chk("align_req", {31'd0, inst_req}, 32'd1);
    chk("align_addr", inst_addr, 32'h100);
    inst_addr_ok = 1'b1;
    lat = 3;
    tick();
    rst = 1'b0;
    inst_addr_ok = 1'b0;
    tick();
    chk("mid_rst_req", {31'd0, inst_req}, 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    rst = 1'b1;
    saw_valid = 1'b0;
    tick();
    chk("post_rst_addr", inst_addr, 32'h0);
    tick();
    chk("late_dok", {31'd0, inst_data_ok}, 32'd1);
    tick();
    chk("late_req", {31'd0, inst_req}, 32'd1);
    chk("late_addr", inst_addr, 32'h0);
    chk("late_ignored", {31'd0, saw_valid}, 32'd0);
    inst_addr_ok = 1'b1;
    lat = 0;
    wait_valid(32'h0, 32'h1111_1111, "wpost");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
